serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 92 +++++++++
 tb/tb_serial_subtractor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// A single full-subtractor cell is reused WIDTH times; start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg, r_sh_reg;
    logic             borrow_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] diff_reg;
    logic             bout_reg;

    logic bit_d, bit_b;

    // Full-subtractor cell on the current LSBs
    assign bit_d = a_sh_reg[0] ^ b_sh_reg[0] ^ borrow_reg;
    assign bit_b = (~a_sh_reg[0] & b_sh_reg[0]) |
                   (borrow_reg & ~(a_sh_reg[0] ^ b_sh_reg[0]));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt_reg == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            r_sh_reg   <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_sh_reg   <= A;
                        b_sh_reg   <= B;
                        borrow_reg <= Bin;
                        cnt_reg    <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    borrow_reg <= bit_b;
                    r_sh_reg   <= {bit_d, r_sh_reg[WIDTH-1:1]};
                    if (cnt_reg == LAST) begin
                        // Counter parks at zero rather than running past the last bit
                        cnt_reg  <= '0;
                        diff_reg <= {bit_d, r_sh_reg[WIDTH-1:1]};
                        bout_reg <= bit_b;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);
    assign Diff = diff_reg;
    assign Bout = bout_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, hand sequences for
// hold/back-to-back/reset corners, and randomized ops at WIDTH=8 and WIDTH=5.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    logic       start5, bin5, busy5, done5, bout5;
    logic [4:0] a5, b5, diff5;

    int checks = 0;
    int errors = 0;
    int accepted8 = 0, accepted5 = 0;
    int done_cnt8 = 0, done_cnt5 = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Bin(bin8),
        .busy(busy8), .done(done8), .Diff(diff8), .Bout(bout8)
    );

    serial_subtractor #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .A(a5), .B(b5), .Bin(bin5),
        .busy(busy5), .done(done5), .Diff(diff5), .Bout(bout5)
    );

    always @(posedge clk) begin
        if (done8 === 1'b1) done_cnt8++;
        if (done5 === 1'b1) done_cnt5++;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction, borrow is the sign of the true result
    function automatic void ref_sub(input int w, input int a, input int b, input int bin,
                                    output int d, output int bo);
        int r;
        r  = a - b - bin;
        d  = r & ((1 << w) - 1);
        bo = (r < 0) ? 1 : 0;
    endfunction

    task automatic op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                      output logic [7:0] d, output logic bo);
        int lat, busyc;
        bit got;
        @(negedge clk);
        if (w == 8) begin
            start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
        end else begin
            start5 = 1'b1; a5 = a[4:0]; b5 = b[4:0]; bin5 = bin;
        end
        @(negedge clk);
        start8 = 1'b0;
        start5 = 1'b0;
        // Scramble operands so a design that re-reads them mid-operation is caught
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
        a5 = 5'($urandom); b5 = 5'($urandom); bin5 = 1'($urandom);
        lat = 1; busyc = 0; got = 0;
        for (int k = 0; k < 40; k++) begin
            if ((w == 8) ? busy8 : busy5) busyc++;
            if ((w == 8) ? done8 : done5) begin
                got = 1;
                break;
            end
            @(negedge clk);
            lat++;
        end
        check("done_seen", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(w + 1));
        check("busy_cycles", 32'(busyc), 32'(w));
        d  = (w == 8) ? diff8 : {3'b000, diff5};
        bo = (w == 8) ? bout8 : bout5;
        if (w == 8) accepted8++; else accepted5++;
        $display("op w=%0d A=%02h B=%02h Bin=%0d -> Diff=%02h Bout=%0d lat=%0d", w, a, b, bin, d, bo, lat);
    endtask

    initial begin
        logic [7:0] d;
        logic       bo;
        logic [7:0] av[50], bv[50];
        logic       bnv[50];
        int ed, eb, dc;
        logic exp_done;

        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[5] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0};
        vecs[6] = '{8'h80, 8'h01, 1'b1, 8'h7E, 1'b0};

        rst = 1'b1;
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;
        start5 = 1'b1; a5 = 5'h1A; b5 = 5'h05; bin5 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_diff8", 32'(diff8), 32'd0);
        check("rst_bout8", 32'(bout8), 32'd0);
        check("rst_busy5", 32'(busy5), 32'd0);
        check("rst_diff5", 32'(diff5), 32'd0);
        rst = 1'b0; start8 = 1'b0; start5 = 1'b0;

        for (int i = 0; i < 7; i++) begin
            op(8, vecs[i].a, vecs[i].b, vecs[i].bin, d, bo);
            check("vec_diff", 32'(d), 32'(vecs[i].diff));
            check("vec_bout", 32'(bo), 32'(vecs[i].bout));
        end

        // Result 0x7E/0 must hold through idle and the next operation's SHIFT phase
        repeat (5) begin
            @(negedge clk);
            check("hold_idle_diff", 32'(diff8), 32'h7E);
            check("hold_idle_bout", 32'(bout8), 32'd0);
        end
        start8 = 1'b1; a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("hold_shift_busy", 32'(busy8), 32'd1);
            check("hold_shift_diff", 32'(diff8), 32'h7E);
            @(negedge clk);
        end
        check("hold_next_done", 32'(done8), 32'd1);
        check("hold_next_diff", 32'(diff8), 32'h02);
        accepted8++;
        $display("op w=8 A=05 B=03 Bin=0 -> Diff=%02h Bout=%0d (hold sequence)", diff8, bout8);

        // start held high: accepts at edges 0,10,20,...; done at edges 8,18,...
        for (int i = 0; i <= 50; i++) begin
            @(negedge clk);
            exp_done = (i % 10 == 9);
            check("held_done", 32'(done8), 32'(exp_done));
            if (exp_done) begin
                ref_sub(8, int'(av[i-9]), int'(bv[i-9]), int'(bnv[i-9]), ed, eb);
                check("held_diff", 32'(diff8), 32'(ed));
                check("held_bout", 32'(bout8), 32'(eb));
                $display("op w=8 A=%02h B=%02h Bin=%0d -> Diff=%02h Bout=%0d (held start)",
                         av[i-9], bv[i-9], bnv[i-9], diff8, bout8);
            end
            if (i < 50) begin
                av[i] = 8'($urandom); bv[i] = 8'($urandom); bnv[i] = 1'($urandom);
                start8 = 1'b1; a8 = av[i]; b8 = bv[i]; bin8 = bnv[i];
            end else begin
                start8 = 1'b0;
            end
        end
        accepted8 += 5;
        repeat (3) @(negedge clk);

        // Reset while processing bit 4 of 0x10 - 0x01
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy8), 32'd0);
        check("midrst_done", 32'(done8), 32'd0);
        check("midrst_diff", 32'(diff8), 32'd0);
        check("midrst_bout", 32'(bout8), 32'd0);
        rst = 1'b0; start8 = 1'b0;
        dc = done_cnt8;
        repeat (12) @(negedge clk);
        check("midrst_no_done", 32'(done_cnt8), 32'(dc));
        op(8, 8'h10, 8'h01, 1'b0, d, bo);
        check("midrst_diff_after", 32'(d), 32'h0F);
        check("midrst_bout_after", 32'(bo), 32'd0);

        foreach (av[j]) av[j] = '0;
        for (int w = 8; w >= 5; w -= 3) begin
            for (int n = 0; n < 500; n++) begin
                logic [7:0] ra, rb;
                logic       rbin;
                ra   = 8'($urandom_range(0, (1 << w) - 1));
                rb   = 8'($urandom_range(0, (1 << w) - 1));
                rbin = 1'($urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                op(w, ra, rb, rbin, d, bo);
                ref_sub(w, int'(ra), int'(rb), int'(rbin), ed, eb);
                check("rand_diff", 32'(d), 32'(ed));
                check("rand_bout", 32'(bo), 32'(eb));
            end
        end

        repeat (4) @(negedge clk);
        check("done_count8", 32'(done_cnt8), 32'(accepted8));
        check("done_count5", 32'(done_cnt5), 32'(accepted5));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
